// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register for the 5-stage RISC-V core. Selects forwarded
//   operands in ID, detects load-use hazards (holding ID and injecting one
//   bubble), squashes on branch flush and holds under EX back-pressure.
//
// Optional feature macro: LOAD_USE_DETECT_EN
//   defined     : load-use detection active, stall_count counts bubbles.
//   not defined : no hazard detection, stall_count reads 0,
//                 id_stall = ~ex_ready.
//
// Ports
//   clk, rst                       clock (rising), async active-high reset
//   id_valid                       ID instruction is real
//   id_Rs1/id_Rs2/id_Rd            register indices
//   id_usesRs1/id_usesRs2          instruction reads that source
//   id_rs1Data/id_rs2Data          register-file read data
//   id_imm/id_pc/id_ctrl           decoded fields passed to EX
//   id_regWrite/memRead/memWrite   control bits
//   forwardA/forwardB              00 RF, 10 EX, 01 MEM, 11 treated as RF
//   ex_aluResult/mem_result        forwarding sources
//   flush                          squash ID/EX (taken branch/jump in EX)
//   ex_ready                       EX can accept; low holds the stage
//   id_stall                       combinational: hold PC and IF/ID
//   ex_*                           registered EX-stage fields
//   stall_count                    saturating load-use bubble counter
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int unsigned REG_NUM_BITWIDTH = 5,
  parameter int unsigned WORD_BITWIDTH    = 32,
  parameter int unsigned CTRL_BITWIDTH    = 8,
  parameter int unsigned CNT_BITWIDTH     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [REG_NUM_BITWIDTH-1:0] id_Rs1,
  input  logic [REG_NUM_BITWIDTH-1:0] id_Rs2,
  input  logic [REG_NUM_BITWIDTH-1:0] id_Rd,
  input  logic                        id_usesRs1,
  input  logic                        id_usesRs2,
  input  logic [WORD_BITWIDTH-1:0]    id_rs1Data,
  input  logic [WORD_BITWIDTH-1:0]    id_rs2Data,
  input  logic [WORD_BITWIDTH-1:0]    id_imm,
  input  logic [WORD_BITWIDTH-1:0]    id_pc,
  input  logic [CTRL_BITWIDTH-1:0]    id_ctrl,
  input  logic                        id_regWrite,
  input  logic                        id_memRead,
  input  logic                        id_memWrite,
  input  logic [1:0]                  forwardA,
  input  logic [1:0]                  forwardB,
  input  logic [WORD_BITWIDTH-1:0]    ex_aluResult,
  input  logic [WORD_BITWIDTH-1:0]    mem_result,
  input  logic                        flush,
  input  logic                        ex_ready,
  output logic                        id_stall,
  output logic                        ex_valid,
  output logic                        ex_regWrite,
  output logic                        ex_memRead,
  output logic                        ex_memWrite,
  output logic [REG_NUM_BITWIDTH-1:0] ex_Rs1,
  output logic [REG_NUM_BITWIDTH-1:0] ex_Rs2,
  output logic [REG_NUM_BITWIDTH-1:0] ex_Rd,
  output logic [WORD_BITWIDTH-1:0]    ex_opA,
  output logic [WORD_BITWIDTH-1:0]    ex_opB,
  output logic [WORD_BITWIDTH-1:0]    ex_storeData,
  output logic [WORD_BITWIDTH-1:0]    ex_imm,
  output logic [WORD_BITWIDTH-1:0]    ex_pc,
  output logic [CTRL_BITWIDTH-1:0]    ex_ctrl,
  output logic [CNT_BITWIDTH-1:0]     stall_count
);

  localparam int unsigned RW = REG_NUM_BITWIDTH;
  localparam int unsigned WW = WORD_BITWIDTH;
  localparam int unsigned CW = CTRL_BITWIDTH;

  localparam logic [1:0] FWD_EX  = 2'b10;
  localparam logic [1:0] FWD_MEM = 2'b01;

  // Payload carried from ID into EX
  typedef struct packed {
    logic          valid;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rd;
    logic [WW-1:0] op_a;
    logic [WW-1:0] op_b;
    logic [WW-1:0] store_data;
    logic [WW-1:0] imm;
    logic [WW-1:0] pc;
    logic [CW-1:0] ctrl;
  } ex_bundle_t;

  ex_bundle_t    ex_q, ex_d;
  logic [WW-1:0] op_a_c;
  logic [WW-1:0] op_b_c;
  logic          hz_c;

  // Operand A forwarding mux (11 falls back to the register file)
  always_comb begin
    op_a_c = id_rs1Data;
    case (forwardA)
      FWD_EX:  op_a_c = ex_aluResult;
      FWD_MEM: op_a_c = mem_result;
      default: op_a_c = id_rs1Data;
    endcase
  end

  // Operand B forwarding mux; also feeds the store-data path
  always_comb begin
    op_b_c = id_rs2Data;
    case (forwardB)
      FWD_EX:  op_b_c = ex_aluResult;
      FWD_MEM: op_b_c = mem_result;
      default: op_b_c = id_rs2Data;
    endcase
  end

`ifdef LOAD_USE_DETECT_EN
  logic [CNT_BITWIDTH-1:0] cnt_q, cnt_d;
  logic                    rs1_match_c;
  logic                    rs2_match_c;

  // Consumer in ID reads the destination of a load sitting in EX
  assign rs1_match_c = id_usesRs1 && (id_Rs1 == ex_q.rd);
  assign rs2_match_c = id_usesRs2 && (id_Rs2 == ex_q.rd);
  assign hz_c = id_valid && ex_q.valid && ex_q.mem_read &&
                (ex_q.rd != RW'(0)) && (rs1_match_c || rs2_match_c);

  // Count only bubbles that are actually loaded; saturate at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (hz_c && ex_ready && !flush && (cnt_q != {CNT_BITWIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_BITWIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;
`else
  logic unused_ok;

  // Source-use flags only matter to hazard detection
  assign unused_ok   = id_usesRs1 ^ id_usesRs2;
  assign hz_c        = 1'b0;
  assign stall_count = '0;
`endif

  // Flush is not folded in here; upstream squashes its own state
  assign id_stall = hz_c || !ex_ready;

  // Next-state: flush > hold > bubble > load. Bubbles keep data fields.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d.valid     = 1'b0;
      ex_d.reg_write = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.mem_write = 1'b0;
    end else if (!ex_ready) begin
      ex_d = ex_q;
    end else if (hz_c) begin
      ex_d.valid     = 1'b0;
      ex_d.reg_write = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.mem_write = 1'b0;
    end else begin
      ex_d.valid      = id_valid;
      ex_d.reg_write  = id_regWrite && id_valid;
      ex_d.mem_read   = id_memRead && id_valid;
      ex_d.mem_write  = id_memWrite && id_valid;
      ex_d.rs1        = id_Rs1;
      ex_d.rs2        = id_Rs2;
      ex_d.rd         = id_Rd;
      ex_d.op_a       = op_a_c;
      ex_d.op_b       = op_b_c;
      ex_d.store_data = op_b_c;
      ex_d.imm        = id_imm;
      ex_d.pc         = id_pc;
      ex_d.ctrl       = id_ctrl;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_regWrite  = ex_q.reg_write;
  assign ex_memRead   = ex_q.mem_read;
  assign ex_memWrite  = ex_q.mem_write;
  assign ex_Rs1       = ex_q.rs1;
  assign ex_Rs2       = ex_q.rs2;
  assign ex_Rd        = ex_q.rd;
  assign ex_opA       = ex_q.op_a;
  assign ex_opB       = ex_q.op_b;
  assign ex_storeData = ex_q.store_data;
  assign ex_imm       = ex_q.imm;
  assign ex_pc        = ex_q.pc;
  assign ex_ctrl      = ex_q.ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage (CNT_BITWIDTH = 2). Directed steps
//   followed by randomized traffic, checked against a behavioural model of
//   the EX-side register contents and the bubble counter.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int unsigned RW = 5;
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned NW = 2;
`ifdef LOAD_USE_DETECT_EN
  localparam bit LUD = 1'b1;
`else
  localparam bit LUD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [RW-1:0] id_Rs1, id_Rs2, id_Rd;
  logic          id_usesRs1, id_usesRs2;
  logic [W-1:0]  id_rs1Data, id_rs2Data, id_imm, id_pc;
  logic [CW-1:0] id_ctrl;
  logic          id_regWrite, id_memRead, id_memWrite;
  logic [1:0]    forwardA, forwardB;
  logic [W-1:0]  ex_aluResult, mem_result;
  logic          flush, ex_ready;
  logic          id_stall;
  logic          ex_valid, ex_regWrite, ex_memRead, ex_memWrite;
  logic [RW-1:0] ex_Rs1, ex_Rs2, ex_Rd;
  logic [W-1:0]  ex_opA, ex_opB, ex_storeData, ex_imm, ex_pc;
  logic [CW-1:0] ex_ctrl;
  logic [NW-1:0] stall_count;

  id_ex_stage #(
    .REG_NUM_BITWIDTH(RW), .WORD_BITWIDTH(W),
    .CTRL_BITWIDTH(CW), .CNT_BITWIDTH(NW)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_Rs1(id_Rs1), .id_Rs2(id_Rs2), .id_Rd(id_Rd),
    .id_usesRs1(id_usesRs1), .id_usesRs2(id_usesRs2),
    .id_rs1Data(id_rs1Data), .id_rs2Data(id_rs2Data),
    .id_imm(id_imm), .id_pc(id_pc), .id_ctrl(id_ctrl),
    .id_regWrite(id_regWrite), .id_memRead(id_memRead), .id_memWrite(id_memWrite),
    .forwardA(forwardA), .forwardB(forwardB),
    .ex_aluResult(ex_aluResult), .mem_result(mem_result),
    .flush(flush), .ex_ready(ex_ready), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_regWrite(ex_regWrite),
    .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_Rs1(ex_Rs1), .ex_Rs2(ex_Rs2), .ex_Rd(ex_Rd),
    .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_storeData(ex_storeData),
    .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_ctrl(ex_ctrl),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model: what EX should hold, and the bubble tally
  logic          m_valid, m_rw, m_mr, m_mw;
  logic [RW-1:0] m_rs1, m_rs2, m_rd;
  logic [W-1:0]  m_opa, m_opb, m_sd, m_imm, m_pc;
  logic [CW-1:0] m_ctrl;
  int            m_cnt;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    {m_valid, m_rw, m_mr, m_mw} = '0;
    m_rs1 = '0; m_rs2 = '0; m_rd = '0;
    m_opa = '0; m_opb = '0; m_sd = '0; m_imm = '0; m_pc = '0;
    m_ctrl = '0; m_cnt = 0;
  endtask

  function automatic logic [W-1:0] pick(input logic [1:0] sel, input logic [W-1:0] rf);
    if (sel == 2'b10) return ex_aluResult;
    if (sel == 2'b01) return mem_result;
    return rf;
  endfunction

  // A load in EX whose nonzero destination the ID instruction reads
  function automatic logic model_hz();
    logic reads;
    reads = (id_usesRs1 && id_Rs1 == m_rd) || (id_usesRs2 && id_Rs2 == m_rd);
    return LUD && id_valid && m_valid && m_mr && (m_rd != 0) && reads;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".ex_valid"},     W'(ex_valid),     W'(m_valid));
    chk({tag, ".ex_regWrite"},  W'(ex_regWrite),  W'(m_rw));
    chk({tag, ".ex_memRead"},   W'(ex_memRead),   W'(m_mr));
    chk({tag, ".ex_memWrite"},  W'(ex_memWrite),  W'(m_mw));
    chk({tag, ".ex_Rs1"},       W'(ex_Rs1),       W'(m_rs1));
    chk({tag, ".ex_Rs2"},       W'(ex_Rs2),       W'(m_rs2));
    chk({tag, ".ex_Rd"},        W'(ex_Rd),        W'(m_rd));
    chk({tag, ".ex_opA"},       ex_opA,           m_opa);
    chk({tag, ".ex_opB"},       ex_opB,           m_opb);
    chk({tag, ".ex_storeData"}, ex_storeData,     m_sd);
    chk({tag, ".ex_imm"},       ex_imm,           m_imm);
    chk({tag, ".ex_pc"},        ex_pc,            m_pc);
    chk({tag, ".ex_ctrl"},      W'(ex_ctrl),      W'(m_ctrl));
    chk({tag, ".stall_count"},  W'(stall_count),  W'(m_cnt));
  endtask

  // One clock: check id_stall before the edge, advance model, check EX after
  task automatic step(input string tag);
    logic hz;
    #1;
    hz = model_hz();
    chk({tag, ".id_stall"}, W'(id_stall), W'(hz || !ex_ready));
    @(posedge clk);
    if (flush) begin
      {m_valid, m_rw, m_mr, m_mw} = '0;
    end else if (!ex_ready) begin
      m_valid = m_valid;
    end else if (hz) begin
      {m_valid, m_rw, m_mr, m_mw} = '0;
      if (m_cnt < (1 << NW) - 1) m_cnt++;
    end else begin
      m_valid = id_valid;
      m_rw = id_valid && id_regWrite;
      m_mr = id_valid && id_memRead;
      m_mw = id_valid && id_memWrite;
      m_rs1 = id_Rs1; m_rs2 = id_Rs2; m_rd = id_Rd;
      m_opa = pick(forwardA, id_rs1Data);
      m_opb = pick(forwardB, id_rs2Data);
      m_sd  = m_opb;
      m_imm = id_imm; m_pc = id_pc; m_ctrl = id_ctrl;
    end
    #1;
    check_all(tag);
  endtask

  // Present a valid instruction with random data and RF-selected operands
  task automatic issue(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                       input logic [RW-1:0] rd, input logic u1, input logic u2,
                       input logic rw, input logic mr);
    id_valid = 1'b1;
    id_Rs1 = rs1; id_Rs2 = rs2; id_Rd = rd;
    id_usesRs1 = u1; id_usesRs2 = u2;
    id_regWrite = rw; id_memRead = mr; id_memWrite = 1'b0;
    id_rs1Data = $urandom; id_rs2Data = $urandom;
    id_imm = $urandom; id_pc = $urandom; id_ctrl = CW'($urandom);
    ex_aluResult = $urandom; mem_result = $urandom;
    forwardA = 2'b00; forwardB = 2'b00;
    flush = 1'b0; ex_ready = 1'b1;
  endtask

  logic [W-1:0] snap_opa;
  int           snap_cnt;

  initial begin
    rst = 1'b1;
    issue(0, 0, 0, 0, 0, 0, 0);
    id_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // ld x5 then add x6,x5,x7: one bubble, then MEM forward
    issue(0, 0, 5, 0, 0, 1, 1);
    step("ld");
    issue(5, 7, 6, 1, 1, 1, 0);
    step("lu_bubble");
    forwardA = 2'b01;
    mem_result = 32'hDEADBEEF;
    step("lu_fwd");
    chk("lu.opA", ex_opA, 32'hDEADBEEF);
    chk("lu.count", W'(stall_count), LUD ? 32'd1 : 32'd0);

    // EX forward on A, MEM forward on B
    issue(1, 2, 3, 1, 1, 1, 0);
    forwardA = 2'b10; ex_aluResult = 32'h1234;
    forwardB = 2'b01; mem_result = 32'h55;
    step("fwd");
    chk("fwd.opA", ex_opA, 32'h1234);
    chk("fwd.opB", ex_opB, 32'h55);
    chk("fwd.sd", ex_storeData, 32'h55);

    // Reserved select 11 reads the register file
    issue(1, 2, 3, 1, 1, 1, 0);
    forwardA = 2'b11; id_rs1Data = 32'hA5;
    step("fwd11");
    chk("fwd11.opA", ex_opA, 32'hA5);

    // Load to x0 never stalls a consumer of x0
    issue(0, 0, 0, 0, 0, 1, 1);
    step("ld_x0");
    issue(0, 0, 8, 1, 1, 1, 0);
    #1;
    chk("x0.nostall", W'(id_stall), 32'd0);
    step("use_x0");

    // Back-pressure for 3 cycles, release uses MEM value at release edge
    issue(4, 4, 9, 1, 0, 1, 0);
    step("pre_hold");
    snap_opa = ex_opA;
    issue(2, 3, 11, 1, 1, 1, 0);
    ex_ready = 1'b0;
    repeat (3) step("hold");
    chk("hold.opA_stable", ex_opA, snap_opa);
    ex_ready = 1'b1;
    forwardA = 2'b01;
    mem_result = 32'hC0FFEE01;
    step("release");
    chk("release.opA", ex_opA, 32'hC0FFEE01);

    // Flush together with a load-use hazard
    issue(0, 0, 9, 0, 0, 1, 1);
    step("ld_x9");
    snap_cnt = int'(stall_count);
    issue(9, 1, 12, 1, 1, 1, 0);
    flush = 1'b1;
    #1;
    chk("flush_hz.stall", W'(id_stall), W'(LUD));
    step("flush_hz");
    chk("flush_hz.valid", W'(ex_valid), 32'd0);
    chk("flush_hz.count", W'(stall_count), W'(snap_cnt));
    flush = 1'b0;

    // Five more load-use pairs saturate a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      issue(0, 0, 10, 0, 0, 1, 1);
      step("sat_ld");
      issue(3, 10, 13, 1, 1, 1, 0);
      step("sat_use");
    end
    chk("sat.count", W'(stall_count), LUD ? 32'd3 : 32'd0);

    // Asynchronous reset in the middle of a hold
    issue(1, 2, 14, 1, 1, 1, 0);
    step("pre_rst");
    ex_ready = 1'b0;
    step("rst_hold");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(5, 6, 15, 1, 1, 1, 0);
    step("post_rst");

    // Randomized traffic with small register indices to provoke hazards
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 7) != 0);
      id_Rs1 = RW'($urandom_range(0, 3));
      id_Rs2 = RW'($urandom_range(0, 3));
      id_Rd  = RW'($urandom_range(0, 3));
      id_usesRs1 = 1'($urandom); id_usesRs2 = 1'($urandom);
      id_regWrite = 1'($urandom); id_memRead = 1'($urandom);
      id_memWrite = 1'($urandom);
      id_rs1Data = $urandom; id_rs2Data = $urandom;
      id_imm = $urandom; id_pc = $urandom; id_ctrl = CW'($urandom);
      forwardA = 2'($urandom); forwardB = 2'($urandom);
      ex_aluResult = $urandom; mem_result = $urandom;
      flush = ($urandom_range(0, 7) == 0);
      ex_ready = ($urandom_range(0, 4) != 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage for the 5-stage RISC-V core. Consumes the Forwarding unit's `forwardA`/`forwardB` selects in ID, muxes register-file, EX-result and MEM-result data into operands, and registers them with the decoded fields into the EX stage. Owns load-use hazard detection: it holds ID and injects a bubble. It also handles branch flush and downstream back-pressure.

## Interface

Parameters:
- `REG_NUM_BITWIDTH`, default 5: register index width.
- `WORD_BITWIDTH`, default 32: data, immediate and PC width.
- `CTRL_BITWIDTH`, default 8: opaque ALU/branch control bundle passed to EX.
- `CNT_BITWIDTH`, default 16: width of the stall counter.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: the ID instruction is real.
- `id_Rs1`, `id_Rs2`, `id_Rd` in `REG_NUM_BITWIDTH`: register indices.
- `id_usesRs1`, `id_usesRs2` in 1: the instruction reads this source.
- `id_rs1Data`, `id_rs2Data` in `WORD_BITWIDTH`: register-file read data.
- `id_imm`, `id_pc` in `WORD_BITWIDTH`: immediate and PC.
- `id_ctrl` in `CTRL_BITWIDTH`: control bundle.
- `id_regWrite`, `id_memRead`, `id_memWrite` in 1: control bits.
- `forwardA`, `forwardB` in 2: forwarding selects. 00 selects the register file, 10 selects EX, 01 selects MEM, 11 is reserved and treated as 00.
- `ex_aluResult` in `WORD_BITWIDTH`: result of the instruction currently in EX.
- `mem_result` in `WORD_BITWIDTH`: result of the instruction currently in MEM.
- `flush` in 1: taken branch/jump resolved in EX; squash the ID/EX contents.
- `ex_ready` in 1: EX can accept; low means hold.
- `id_stall` out 1: hold PC and IF/ID this cycle.
- `ex_valid`, `ex_regWrite`, `ex_memRead`, `ex_memWrite` out 1: registered control bits.
- `ex_Rs1`, `ex_Rs2`, `ex_Rd` out `REG_NUM_BITWIDTH`: registered register indices.
- `ex_opA`, `ex_opB`, `ex_storeData`, `ex_imm`, `ex_pc` out `WORD_BITWIDTH`: registered operands and fields.
- `ex_ctrl` out `CTRL_BITWIDTH`: registered control bundle.
- `stall_count` out `CNT_BITWIDTH`: load-use bubble count.

## Operation

- Operand mux is combinational in ID. `opA` is selected by `forwardA` and `opB` by `forwardB`. `ex_storeData` latches the forwarded `opB` value; immediate selection happens in EX.
- Load-use hazard: `hz = id_valid & ex_valid & ex_memRead & ex_Rd!=0 & ((id_usesRs1 & id_Rs1==ex_Rd) | (id_usesRs2 & id_Rs2==ex_Rd))`.
- `id_stall = hz | ~ex_ready`, combinational. `flush` does not suppress `id_stall`; upstream handles its own flush.
- Register update priority, highest first:
  - `rst`: all outputs 0.
  - `flush`: load a bubble.
  - `~ex_ready`: hold all registers.
  - `hz`: load a bubble.
  - otherwise: load the ID fields and forwarded operands.
- Bubble: `ex_valid`, `ex_regWrite`, `ex_memRead`, `ex_memWrite` = 0. Data fields are don't-care and are implemented as held.
- `ex_regWrite`, `ex_memRead`, `ex_memWrite` are loaded ANDed with `id_valid`.
- `stall_count` increments on each cycle in which a load-use bubble is actually loaded (`hz & ex_ready & ~flush`). It saturates at all-ones and is cleared only by `rst`.

## Timing

- Latency is one cycle, ID to EX outputs.
- A load-use hazard costs exactly one bubble. On the next cycle the load is in MEM, Forwarding returns 01, and `hz` drops.
- `ex_ready` low holds the stage for N cycles with `id_stall` high. The `mem_result` forward value sampled on the release edge is used.
- Simultaneous `flush` and `hz`: a bubble is loaded, `stall_count` is unchanged, and `id_stall` is still high.
- Asserting `rst` mid-operation clears all outputs asynchronously. The first edge after deassertion loads normally.

## Configuration

- `LOAD_USE_DETECT_EN` defined: hazard detection as above.
- Not defined: `hz` is tied to 0, `stall_count` is tied to 0, `id_stall = ~ex_ready`. Software scheduling must then avoid load-use pairs.

## Test plan

- Reset then `ld x5` followed by `add x6,x5,x7`: `id_stall`=1 for one cycle and one bubble is loaded. The next cycle `ex_opA` equals the MEM data 0xDEADBEEF and `stall_count`=1.
- `forwardA`=10 with `ex_aluResult`=0x1234 and `forwardB`=01 with `mem_result`=0x55: next cycle `ex_opA`=0x1234, `ex_opB`=0x55 and `ex_storeData`=0x55.
- `forwardA`=11 with `id_rs1Data`=0xA5: `ex_opA`=0xA5.
- Load in EX with `ex_Rd`=0 and a consumer of x0: no stall.
- `ex_ready` low for 3 cycles: EX outputs are stable and `id_stall`=1 for 3 cycles. `flush` together with `hz`: `ex_valid`=0 and the count is unchanged.
- `CNT_BITWIDTH`=2 with 5 load-use hazards: `stall_count` saturates at 3. Asserting `rst` mid-hold clears all outputs immediately.
